// File: rtl/alu_collect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_collect_pkg
//  Description : Shared types and constants for the ALU operand collector:
//                state encoding, INP_VALID encodings and the default-width
//                operand bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_collect_pkg;

    // Collector state machine encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // INP_VALID encodings: bit0 = OPA valid, bit1 = OPB valid
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    // Default operand/command widths of the bundle below
    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_CMD_WIDTH  = 4;

    // One complete operand bundle at the default widths
    typedef struct packed {
        logic [c_DEF_DATA_WIDTH-1:0] opa;
        logic [c_DEF_DATA_WIDTH-1:0] opb;
        logic                        cin;
        logic                        mode;
        logic [c_DEF_CMD_WIDTH-1:0]  cmd;
    } bundle_t;

endpackage
`default_nettype wire

// File: rtl/alu_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_timeout_timer
//  Description : Partner-operand wait timer. Counts enabled cycles, clears on
//                request and flags the last cycle of the allowed window.
//                The count saturates and never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMR_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_timer_q;
    logic [c_TW-1:0] w_timer_d;

    // Next timer value: clear wins, otherwise count up to the last window cycle
    always_comb begin
        w_timer_d = r_timer_q;
        if (ce) begin
            if (clear) begin
                w_timer_d = '0;
            end else if (count && (r_timer_q != c_TMR_LAST)) begin
                w_timer_d = r_timer_q + 1'b1;
            end
        end
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer_q <= '0;
        end else begin
            r_timer_q <= w_timer_d;
        end
    end

    assign expired = (r_timer_q == c_TMR_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_operand_collector.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_collector
//  Description : Pairs OPA/OPB (arriving together or split across cycles)
//                with CMD/MODE/CIN and issues one bundle to the ALU over a
//                valid/ready handshake. A missing partner operand raises a
//                one-cycle ERR pulse after TIMEOUT_CYCLES enabled cycles.
//                Optional macro ALU_COLLECT_STATS_EN adds saturating pair and
//                timeout counters (pair_cnt, timeout_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_collector
    import alu_collect_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CMD_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
`ifdef ALU_COLLECT_STATS_EN
    ,
    parameter int CNT_WIDTH      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] OPA,
    input  logic [DATA_WIDTH-1:0] OPB,
    input  logic                  CIN,
    input  logic                  MODE,
    input  logic [CMD_WIDTH-1:0]  CMD,
    input  logic [1:0]            INP_VALID,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_opa,
    output logic [DATA_WIDTH-1:0] out_opb,
    output logic                  out_cin,
    output logic                  out_mode,
    output logic [CMD_WIDTH-1:0]  out_cmd,
    output logic                  ERR
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  pair_cnt,
    output logic [CNT_WIDTH-1:0]  timeout_cnt
`endif
);

    // Bundle sized to this instance's parameters
    typedef struct packed {
        logic [DATA_WIDTH-1:0] opa;
        logic [DATA_WIDTH-1:0] opb;
        logic                  cin;
        logic                  mode;
        logic [CMD_WIDTH-1:0]  cmd;
    } coll_bundle_t;

    state_t       r_state_q;
    state_t       w_state_d;
    coll_bundle_t r_bundle_q;
    coll_bundle_t w_bundle_d;
    logic         r_err_q;
    logic         w_err_d;

    state_t       w_fresh_state;
    coll_bundle_t w_fresh_bundle;

    logic         w_tmr_clr;
    logic         w_tmr_cnt;
    logic         w_tmr_exp;

    // Evaluation of the inputs from an empty collector (IDLE or HOLD handshake)
    always_comb begin
        w_fresh_state  = IDLE;
        w_fresh_bundle = r_bundle_q;
        case (INP_VALID)
            IV_AB: begin
                w_fresh_state       = HOLD;
                w_fresh_bundle.opa  = OPA;
                w_fresh_bundle.opb  = OPB;
                w_fresh_bundle.cin  = CIN;
                w_fresh_bundle.mode = MODE;
                w_fresh_bundle.cmd  = CMD;
            end
            IV_A: begin
                w_fresh_state       = WAIT_B;
                w_fresh_bundle.opa  = OPA;
                w_fresh_bundle.opb  = '0;
                w_fresh_bundle.cin  = CIN;
                w_fresh_bundle.mode = MODE;
                w_fresh_bundle.cmd  = CMD;
            end
            IV_B: begin
                w_fresh_state       = WAIT_A;
                w_fresh_bundle.opa  = '0;
                w_fresh_bundle.opb  = OPB;
                w_fresh_bundle.cin  = CIN;
                w_fresh_bundle.mode = MODE;
                w_fresh_bundle.cmd  = CMD;
            end
            IV_NONE: begin
                w_fresh_state = IDLE;
            end
        endcase
    end

    // Next-state, bundle capture, timer control and timeout detection
    always_comb begin
        w_state_d  = r_state_q;
        w_bundle_d = r_bundle_q;
        w_err_d    = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_cnt  = 1'b0;
        if (CE) begin
            case (r_state_q)
                IDLE: begin
                    w_state_d  = w_fresh_state;
                    w_bundle_d = w_fresh_bundle;
                    w_tmr_clr  = 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_d  = w_fresh_state;
                        w_bundle_d = w_fresh_bundle;
                        w_tmr_clr  = 1'b1;
                    end
                end
                WAIT_B: begin
                    if (INP_VALID[1]) begin
                        // Partner arrived: first-half CMD/MODE/CIN are kept
                        w_bundle_d.opb = OPB;
                        w_state_d      = HOLD;
                        w_tmr_clr      = 1'b1;
                    end else if (w_tmr_exp) begin
                        w_bundle_d = '0;
                        w_state_d  = IDLE;
                        w_err_d    = 1'b1;
                        w_tmr_clr  = 1'b1;
                    end else if (INP_VALID[0]) begin
                        // A newer first half replaces the old one and restarts the window
                        w_bundle_d.opa  = OPA;
                        w_bundle_d.cin  = CIN;
                        w_bundle_d.mode = MODE;
                        w_bundle_d.cmd  = CMD;
                        w_tmr_clr       = 1'b1;
                    end else begin
                        w_tmr_cnt = 1'b1;
                    end
                end
                WAIT_A: begin
                    if (INP_VALID[0]) begin
                        w_bundle_d.opa = OPA;
                        w_state_d      = HOLD;
                        w_tmr_clr      = 1'b1;
                    end else if (w_tmr_exp) begin
                        w_bundle_d = '0;
                        w_state_d  = IDLE;
                        w_err_d    = 1'b1;
                        w_tmr_clr  = 1'b1;
                    end else if (INP_VALID[1]) begin
                        w_bundle_d.opb  = OPB;
                        w_bundle_d.cin  = CIN;
                        w_bundle_d.mode = MODE;
                        w_bundle_d.cmd  = CMD;
                        w_tmr_clr       = 1'b1;
                    end else begin
                        w_tmr_cnt = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and bundle registers, frozen while CE is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= IDLE;
            r_bundle_q <= '0;
        end else if (CE) begin
            r_state_q  <= w_state_d;
            r_bundle_q <= w_bundle_d;
        end
    end

    // ERR pulse register; drops to 0 whenever CE is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    alu_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .ce      (CE),
        .clear   (w_tmr_clr),
        .count   (w_tmr_cnt),
        .expired (w_tmr_exp)
    );

    assign out_valid = (r_state_q == HOLD);
    assign in_ready  = (r_state_q != HOLD) || out_ready;
    assign out_opa   = r_bundle_q.opa;
    assign out_opb   = r_bundle_q.opb;
    assign out_cin   = r_bundle_q.cin;
    assign out_mode  = r_bundle_q.mode;
    assign out_cmd   = r_bundle_q.cmd;
    assign ERR       = r_err_q;

`ifdef ALU_COLLECT_STATS_EN
    logic [CNT_WIDTH-1:0] r_pair_cnt_q;
    logic [CNT_WIDTH-1:0] w_pair_cnt_d;
    logic [CNT_WIDTH-1:0] r_timeout_cnt_q;
    logic [CNT_WIDTH-1:0] w_timeout_cnt_d;

    // Saturating handshake and timeout counters
    always_comb begin
        w_pair_cnt_d    = r_pair_cnt_q;
        w_timeout_cnt_d = r_timeout_cnt_q;
        if (CE && (r_state_q == HOLD) && out_ready && (r_pair_cnt_q != '1)) begin
            w_pair_cnt_d = r_pair_cnt_q + 1'b1;
        end
        if (w_err_d && (r_timeout_cnt_q != '1)) begin
            w_timeout_cnt_d = r_timeout_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pair_cnt_q    <= '0;
            r_timeout_cnt_q <= '0;
        end else begin
            r_pair_cnt_q    <= w_pair_cnt_d;
            r_timeout_cnt_q <= w_timeout_cnt_d;
        end
    end

    assign pair_cnt    = r_pair_cnt_q;
    assign timeout_cnt = r_timeout_cnt_q;
`endif

endmodule
`default_nettype wire
